// File: rtl/debouncer_multi_if.sv
// Switch-in / debounced-out bundle for debouncer_multi.
interface debouncer_multi_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] sw;
  logic [CHANNELS-1:0] db_level;
  logic [CHANNELS-1:0] db_rise;
  logic [CHANNELS-1:0] db_fall;
  logic [CHANNELS-1:0] db_rpt;

  modport master (output sw, input db_level, db_rise, db_fall, db_rpt);
  modport slave  (input sw, output db_level, db_rise, db_fall, db_rpt);
endinterface

// File: rtl/debouncer_multi.sv
// N-channel switch debouncer: 2-FF synchroniser, stable-count filter, press/release ticks.
// Hold-to-repeat ticks are built only when DEBOUNCER_REPEAT_EN is defined; otherwise db_rpt is 0.
module debouncer_multi #(
  parameter int CHANNELS      = 4,
  parameter int STABLE_CYCLES = 650000,
  parameter int REPEAT_DELAY  = 32500000,
  parameter int REPEAT_PERIOD = 6500000,
  parameter int CNT_W         = 26
) (
  input  logic               pclk,
  input  logic               rst,
  debouncer_multi_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam longint CNT_CAP  = (64'sd1 <<< CNT_W) - 64'sd1;
  localparam longint MAX_REQ  = (longint'(STABLE_CYCLES) > longint'(REPEAT_DELAY)) ?
                                ((longint'(STABLE_CYCLES) > longint'(REPEAT_PERIOD)) ? longint'(STABLE_CYCLES) : longint'(REPEAT_PERIOD)) :
                                ((longint'(REPEAT_DELAY) > longint'(REPEAT_PERIOD)) ? longint'(REPEAT_DELAY) : longint'(REPEAT_PERIOD));

  // Elaboration guard: every counter limit must fit in CNT_W bits.
  if (MAX_REQ > CNT_CAP) begin : g_cnt_w_too_narrow
    $error("debouncer_multi: CNT_W too narrow for configured cycle counts");
  end

  logic [CHANNELS-1:0] s1_r, s2_r;
  logic [CHANNELS-1:0] level_r, rise_r, fall_r, rpt_r;
  logic [CHANNELS-1:0] level_s, rise_s, fall_s, rpt_s;
  logic [CNT_W-1:0]    cnt_r [CHANNELS];
  logic [CNT_W-1:0]    cnt_s [CHANNELS];

  // Filter next state: a level change needs STABLE_CYCLES consecutive disagreeing samples.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_s[i]   = cnt_r[i];
      level_s[i] = level_r[i];
      rise_s[i]  = 1'b0;
      fall_s[i]  = 1'b0;
      if (s2_r[i] == level_r[i]) begin
        cnt_s[i] = CNT_ZERO;
      end else if (cnt_r[i] == STABLE_LAST) begin
        cnt_s[i]   = CNT_ZERO;
        level_s[i] = s2_r[i];
        rise_s[i]  = s2_r[i];
        fall_s[i]  = ~s2_r[i];
      end else begin
        cnt_s[i] = cnt_r[i] + CNT_ONE;
      end
    end
  end

  // Synchroniser, filter counters and registered outputs.
  always_ff @(posedge pclk) begin
    if (rst) begin
      s1_r    <= {CHANNELS{1'b0}};
      s2_r    <= {CHANNELS{1'b0}};
      level_r <= {CHANNELS{1'b0}};
      rise_r  <= {CHANNELS{1'b0}};
      fall_r  <= {CHANNELS{1'b0}};
      rpt_r   <= {CHANNELS{1'b0}};
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
    end else begin
      s1_r    <= bus.sw;
      s2_r    <= s1_r;
      level_r <= level_s;
      rise_r  <= rise_s;
      fall_r  <= fall_s;
      rpt_r   <= rpt_s;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_r[i] <= cnt_s[i];
      end
    end
  end

`ifdef DEBOUNCER_REPEAT_EN
  typedef enum logic {
    PH_FIRST    = 1'b0,
    PH_PERIODIC = 1'b1
  } phase_e;

  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  phase_e           phase_r [CHANNELS];
  phase_e           phase_s [CHANNELS];
  logic [CNT_W-1:0] rcnt_r  [CHANNELS];
  logic [CNT_W-1:0] rcnt_s  [CHANNELS];

  // Repeat next state: only counts while the level was and stays high, so the
  // rise and fall cycles both restart it and can never carry a repeat tick.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      rpt_s[i]   = 1'b0;
      rcnt_s[i]  = rcnt_r[i];
      phase_s[i] = phase_r[i];
      if (level_r[i] && level_s[i]) begin
        case (phase_r[i])
          PH_FIRST: begin
            if (rcnt_r[i] == DELAY_LAST) begin
              rpt_s[i]   = 1'b1;
              rcnt_s[i]  = CNT_ZERO;
              phase_s[i] = PH_PERIODIC;
            end else begin
              rcnt_s[i] = rcnt_r[i] + CNT_ONE;
            end
          end
          PH_PERIODIC: begin
            if (rcnt_r[i] == PERIOD_LAST) begin
              rpt_s[i]  = 1'b1;
              rcnt_s[i] = CNT_ZERO;
            end else begin
              rcnt_s[i] = rcnt_r[i] + CNT_ONE;
            end
          end
          default: begin
            rcnt_s[i]  = CNT_ZERO;
            phase_s[i] = PH_FIRST;
          end
        endcase
      end else begin
        rcnt_s[i]  = CNT_ZERO;
        phase_s[i] = PH_FIRST;
      end
    end
  end

  // Repeat counter and phase registers.
  always_ff @(posedge pclk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        rcnt_r[i]  <= CNT_ZERO;
        phase_r[i] <= PH_FIRST;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        rcnt_r[i]  <= rcnt_s[i];
        phase_r[i] <= phase_s[i];
      end
    end
  end
`else
  assign rpt_s = {CHANNELS{1'b0}};
`endif

  assign bus.db_level = level_r;
  assign bus.db_rise  = rise_r;
  assign bus.db_fall  = fall_r;
  assign bus.db_rpt   = rpt_r;

endmodule

// File: tb/tb_debouncer_multi.sv
// Directed plus random bench for debouncer_multi against a sliding-window reference model.
module tb_debouncer_multi;

  localparam int CH  = 4;
  localparam int SC  = 4;
  localparam int RD  = 10;
  localparam int RP  = 3;

  logic pclk = 1'b0;
  logic rst  = 1'b1;
  int   checks = 0;
  int   errors = 0;

  debouncer_multi_if #(.CHANNELS(CH)) bus ();

  debouncer_multi #(
    .CHANNELS(CH), .STABLE_CYCLES(SC), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .CNT_W(8)
  ) dut (
    .pclk (pclk),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 pclk = ~pclk;

  // Reference model: sw delayed two edges, level flips once the last SC samples all disagree.
  logic [CH-1:0] m_p0, m_p1, m_level, m_rise, m_fall, m_rpt;
  logic [SC-1:0] m_win [CH];
  int            m_hold [CH];

  function automatic void model_step(input logic [CH-1:0] sw_v, input logic r);
    logic [CH-1:0] f;
    logic          old_l, new_l;
    if (r) begin
      m_p0 = '0; m_p1 = '0; m_level = '0; m_rise = '0; m_fall = '0; m_rpt = '0;
      for (int c = 0; c < CH; c++) begin
        m_win[c]  = '0;
        m_hold[c] = 0;
      end
    end else begin
      f    = m_p1;
      m_p1 = m_p0;
      m_p0 = sw_v;
      for (int c = 0; c < CH; c++) begin
        m_win[c] = {m_win[c][SC-2:0], f[c]};
        old_l    = m_level[c];
        new_l    = (m_win[c] == {SC{~old_l}}) ? ~old_l : old_l;
        m_rise[c] = new_l & ~old_l;
        m_fall[c] = old_l & ~new_l;
        m_rpt[c]  = 1'b0;
        if (old_l && new_l) begin
          m_hold[c] = m_hold[c] + 1;
`ifdef DEBOUNCER_REPEAT_EN
          m_rpt[c] = (m_hold[c] == RD) || (m_hold[c] > RD && ((m_hold[c] - RD) % RP) == 0);
`endif
        end else begin
          m_hold[c] = 0;
        end
        m_level[c] = new_l;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [CH-1:0] got, input logic [CH-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input logic [CH-1:0] sw_v, input logic r);
    bus.sw = sw_v;
    rst    = r;
    @(posedge pclk);
    model_step(sw_v, r);
    @(negedge pclk);
    chk("db_level", bus.db_level, m_level);
    chk("db_rise",  bus.db_rise,  m_rise);
    chk("db_fall",  bus.db_fall,  m_fall);
    chk("db_rpt",   bus.db_rpt,   m_rpt);
  endtask

  initial begin
    int            first;
    int            cnt;
    int            rise_at;
    int            rpt_q[$];
    logic [CH-1:0] sw_v;
    logic          r;

    bus.sw = '0;
    model_step('0, 1'b1);
    @(negedge pclk);

    // Reset with all switches pressed, then first rise six edges after release
    tick(4'hF, 1'b1);
    chk("reset_zero", bus.db_level | bus.db_rise | bus.db_fall | bus.db_rpt, 4'h0);
    tick(4'hF, 1'b1);
    first = -1;
    for (int i = 1; i <= 10; i++) begin
      tick(4'hF, 1'b0);
      if (bus.db_rise == 4'hF && first < 0) first = i;
    end
    chk_int("reset_rise_latency", first, 6);

    for (int i = 0; i < 8; i++) tick(4'h0, 1'b0);

    // Clean press on channel 0
    first = -1;
    for (int i = 1; i <= 10; i++) begin
      tick(4'h1, 1'b0);
      if (bus.db_rise[0] && first < 0) first = i;
    end
    chk_int("press_latency", first, 6);

    // Bounce on channel 1: 1,0,1,0 every 2 cycles then hold
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick({2'b00, ~i[1], 1'b1}, 1'b0);
      if (bus.db_rise[1]) cnt++;
    end
    chk_int("bounce_no_tick", cnt, 0);
    first = -1;
    for (int i = 1; i <= 10; i++) begin
      tick(4'h3, 1'b0);
      if (bus.db_rise[1]) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    chk_int("bounce_single_rise", cnt, 1);
    chk_int("bounce_latency", first, 6);

    // Glitch reject then real release on channel 2
    for (int i = 0; i < 8; i++) tick(4'h7, 1'b0);
    cnt = 0;
    for (int i = 0; i < 3; i++) tick(4'h3, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick(4'h7, 1'b0);
      if (bus.db_fall[2]) cnt++;
    end
    chk_int("glitch_no_fall", cnt, 0);
    for (int i = 0; i < 8; i++) begin
      tick(4'h3, 1'b0);
      if (bus.db_fall[2]) cnt++;
    end
    chk_int("release_fall", cnt, 1);
    chk("release_level", {3'b000, bus.db_level[2]}, 4'h0);

    // Simultaneous press on channels 1 and 3 from idle
    for (int i = 0; i < 8; i++) tick(4'h0, 1'b0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick(4'hA, 1'b0);
      if (bus.db_rise == 4'hA) cnt++;
    end
    chk_int("simultaneous_rise", cnt, 1);

    // Reset two cycles before the level would change
    for (int i = 0; i < 8; i++) tick(4'h0, 1'b0);
    for (int i = 0; i < 4; i++) tick(4'hF, 1'b0);
    tick(4'hF, 1'b1);
    tick(4'hF, 1'b1);
    first = -1;
    for (int i = 1; i <= 10; i++) begin
      tick(4'hF, 1'b0);
      if (bus.db_rise == 4'hF && first < 0) first = i;
    end
    chk_int("reset_midfilter_restart", first, 6);

    // Hold channel 3 for repeat ticks, then release
    for (int i = 0; i < 8; i++) tick(4'h0, 1'b0);
    rise_at = 0;
    for (int i = 1; i <= 30; i++) begin
      tick(4'h8, 1'b0);
      if (bus.db_rise[3]) rise_at = i;
      if (bus.db_rpt[3]) rpt_q.push_back(i - rise_at);
    end
`ifdef DEBOUNCER_REPEAT_EN
    chk_int("rpt_count", rpt_q.size(), 5);
    chk_int("rpt_first", rpt_q[0], 10);
    chk_int("rpt_second", rpt_q[1], 13);
    chk_int("rpt_third", rpt_q[2], 16);
`else
    chk_int("rpt_absent", rpt_q.size(), 0);
`endif
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick(4'h0, 1'b0);
      if (bus.db_rpt[3]) cnt++;
    end
    chk_int("rpt_stops", cnt, 0);

    // Random slowly-changing switches with occasional resets
    sw_v = '0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(4, 0) == 0) sw_v[$urandom_range(CH-1, 0)] ^= 1'b1;
      r = ($urandom_range(99, 0) == 0);
      tick(sw_v, r);
    end
    // Long hold to exercise repeat on all channels
    for (int i = 0; i < 40; i++) tick(4'hF, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
